// File: rtl/match_req_dispatcher.sv
// Purpose: spreads one lazy window of match offsets over the match-PE request channels by offset range.
// Latency: window accepted -> first grant next cycle -> ch_valid the cycle after; win_done in the first IDLE cycle.
// Backpressure: in_ready only in IDLE; a channel beat is held while ch_ready is low; busy lanes wait for a free channel.

// Per-lane channel eligibility: bit j of a lane's map is set when that lane's offset
// lies inside channel j's half-open window [CH_LO[j], CH_HI[j]).
module match_req_route_table #(
    parameter int LAZY_LEN        = 4,
    parameter int SEQ_OFFSET_BITS = 20,
    parameter int NUM_CH          = 4,
    parameter logic [NUM_CH*32-1:0] CH_LO = {32'd65536, 32'd0, 32'd0, 32'd0},
    parameter logic [NUM_CH*32-1:0] CH_HI = {32'd1048576, 32'd64768, 32'd32000, 32'd15616}
) (
    input  logic [LAZY_LEN*SEQ_OFFSET_BITS-1:0] offset,
    output logic [LAZY_LEN*NUM_CH-1:0]          route_map
);

    // Range compare every lane against every channel window.
    always_comb begin
        route_map = '0;
        for (int i = 0; i < LAZY_LEN; i++) begin
            for (int j = 0; j < NUM_CH; j++) begin
                if ((32'(offset[i*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS]) >= CH_LO[j*32 +: 32]) &&
                    (32'(offset[i*SEQ_OFFSET_BITS +: SEQ_OFFSET_BITS]) <  CH_HI[j*32 +: 32])) begin
                    route_map[i*NUM_CH + j] = 1'b1;
                end
            end
        end
    end

endmodule

module match_req_dispatcher #(
    parameter int LAZY_LEN         = 4,
    parameter int SEQ_OFFSET_BITS  = 20,
    parameter int NUM_MATCH_REQ_CH = 4,
    parameter int SEQ_ID_BITS      = 16,
    parameter int LANE_BITS        = $clog2(LAZY_LEN),
    parameter logic [NUM_MATCH_REQ_CH*32-1:0] CH_LO = {32'd65536, 32'd0, 32'd0, 32'd0},
    parameter logic [NUM_MATCH_REQ_CH*32-1:0] CH_HI = {32'd1048576, 32'd64768, 32'd32000, 32'd15616}
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [SEQ_ID_BITS-1:0]                       in_seq_id,
    input  logic [LAZY_LEN*SEQ_OFFSET_BITS-1:0]          in_offset,
    input  logic [LAZY_LEN-1:0]                          in_mask,
    output logic [NUM_MATCH_REQ_CH-1:0]                  ch_valid,
    input  logic [NUM_MATCH_REQ_CH-1:0]                  ch_ready,
    output logic [NUM_MATCH_REQ_CH*SEQ_OFFSET_BITS-1:0]  ch_offset,
    output logic [NUM_MATCH_REQ_CH*LANE_BITS-1:0]        ch_lane,
    output logic [NUM_MATCH_REQ_CH*SEQ_ID_BITS-1:0]      ch_seq_id,
    output logic                                         win_done,
    output logic [LAZY_LEN-1:0]                          win_drop_mask
);

    localparam int N = NUM_MATCH_REQ_CH;
    localparam int B = SEQ_OFFSET_BITS;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] DISPATCH = 1'b1;

    logic [0:0]               state;
    logic [LAZY_LEN-1:0]      pending;
    logic [LAZY_LEN-1:0]      drop_q;
    logic [LAZY_LEN*N-1:0]    route_q;
    logic [LAZY_LEN*B-1:0]    off_q;
    logic [SEQ_ID_BITS-1:0]   seq_q;

    logic [LAZY_LEN*N-1:0]    route_map;
    logic [LAZY_LEN-1:0]      routable;
    logic [LAZY_LEN-1:0]      pend_next;
    logic [N-1:0]             ch_free;
    logic [N-1:0]             gnt;
    logic [N*LANE_BITS-1:0]   gnt_lane;
    logic [N*B-1:0]           gnt_off;

    // Eligibility is computed on the incoming window and latched with it,
    // so the dispatch loop never re-evaluates ranges.
    match_req_route_table #(
        .LAZY_LEN        (LAZY_LEN),
        .SEQ_OFFSET_BITS (B),
        .NUM_CH          (N),
        .CH_LO           (CH_LO),
        .CH_HI           (CH_HI)
    ) u_route (
        .offset    (in_offset),
        .route_map (route_map)
    );

    // in_ready is purely a function of state, never of ch_ready.
    assign in_ready = (state == IDLE);

    // A lane with no eligible channel at all is dropped at accept time.
    always_comb begin
        routable = '0;
        for (int i = 0; i < LAZY_LEN; i++) begin
            routable[i] = |route_map[i*N +: N];
        end
    end

    // Channel-ordered grant: channel 0 (smallest PE) picks first, each later
    // channel takes the lowest still-pending eligible lane.
    always_comb begin
        ch_free   = '0;
        gnt       = '0;
        gnt_lane  = '0;
        gnt_off   = '0;
        pend_next = pending;
        for (int j = 0; j < N; j++) begin
            ch_free[j] = !ch_valid[j] || ch_ready[j];
        end
        if (state == DISPATCH) begin
            for (int j = 0; j < N; j++) begin
                if (ch_free[j]) begin
                    for (int i = 0; i < LAZY_LEN; i++) begin
                        if (!gnt[j] && pend_next[i] && route_q[i*N + j]) begin
                            gnt[j]                        = 1'b1;
                            gnt_lane[j*LANE_BITS +: LANE_BITS] = LANE_BITS'(i);
                            gnt_off[j*B +: B]             = off_q[i*B +: B];
                            pend_next[i]                  = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Window sequencing: accept, dispatch until nothing pending, then report completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= '0;
            drop_q        <= '0;
            route_q       <= '0;
            off_q         <= '0;
            seq_q         <= '0;
            win_done      <= 1'b0;
            win_drop_mask <= '0;
        end else begin
            win_done      <= 1'b0;
            win_drop_mask <= '0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        off_q   <= in_offset;
                        seq_q   <= in_seq_id;
                        route_q <= route_map;
                        pending <= in_mask & routable;
                        drop_q  <= in_mask & ~routable;
                        if ((in_mask & routable) == '0) begin
                            win_done      <= 1'b1;
                            win_drop_mask <= in_mask & ~routable;
                        end else begin
                            state <= DISPATCH;
                        end
                    end
                end
                default: begin
                    pending <= pend_next;
                    if (pend_next == '0) begin
                        state         <= IDLE;
                        win_done      <= 1'b1;
                        win_drop_mask <= drop_q;
                    end
                end
            endcase
        end
    end

    // Channel output registers: load on grant, retire on ready, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_valid  <= '0;
            ch_offset <= '0;
            ch_lane   <= '0;
            ch_seq_id <= '0;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (gnt[j]) begin
                    ch_valid[j]                          <= 1'b1;
                    ch_offset[j*B +: B]                  <= gnt_off[j*B +: B];
                    ch_lane[j*LANE_BITS +: LANE_BITS]    <= gnt_lane[j*LANE_BITS +: LANE_BITS];
                    ch_seq_id[j*SEQ_ID_BITS +: SEQ_ID_BITS] <= seq_q;
                end else if (ch_ready[j]) begin
                    ch_valid[j] <= 1'b0;
                end
            end
        end
    end

endmodule
